// File: rtl/anita4_l2_trigger_scheduler.sv
// ANITA-4 L2 trigger scheduler: per-sector rising-edge detection, round-robin
// arbitration with offer/holdoff handshake, lost-trigger count and rate scalers.
module anita4_l2_trigger_scheduler #(
  parameter int NSECT    = 4,
  parameter int HOLDOFF  = 8,
  parameter int SCALER_W = 16,
  localparam int SW      = (NSECT > 1) ? $clog2(NSECT) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NSECT-1:0]    l2,
  input  logic [NSECT-1:0]    enable,
  output logic                trig_valid,
  output logic [SW-1:0]       trig_sector,
  input  logic                trig_ready,
  output logic                busy,
  output logic [7:0]          lost_cnt,
  input  logic                scaler_latch,
  input  logic [SW-1:0]       scaler_sel,
  output logic [SCALER_W-1:0] scaler_data
);

  typedef enum logic [1:0] {S_IDLE, S_OFFER, S_HOLDOFF} state_t;

  state_t             state_reg, state_next;
  logic               valid_reg, valid_next;
  logic [SW-1:0]      sector_reg, sector_next;
  logic [SW-1:0]      last_reg, last_next;
  logic [7:0]         cnt_reg, cnt_next;
  logic               busy_reg;
  logic [7:0]         lost_reg, lost_next;
  logic [NSECT-1:0]   pending_reg, pending_next;
  logic [NSECT-1:0]   l2_q_reg, l2_h_reg;
  logic [NSECT-1:0]   evt, req, lost_evt, grant_vec;
  logic               found, grant_ok;
  logic [SW-1:0]      pick;
  int                 lost_add;

  logic [SCALER_W-1:0] live_reg [NSECT];
  logic [SCALER_W-1:0] hold_reg [NSECT];

  assign evt      = l2_q_reg & ~l2_h_reg & enable;
  assign req      = pending_reg & enable;
  assign lost_evt = evt & pending_reg;

  // Round-robin search starting just above the last granted sector
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NSECT; k++) begin
      int idx;
      idx = (int'(last_reg) + 1 + k) % NSECT;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = SW'(idx);
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    valid_next  = valid_reg;
    sector_next = sector_reg;
    last_next   = last_reg;
    cnt_next    = cnt_reg;
    grant_vec   = '0;
    grant_ok    = 1'b0;
    case (state_reg)
      S_IDLE: grant_ok = 1'b1;
      S_OFFER: begin
        if (trig_ready) begin
          valid_next = 1'b0;
          cnt_next   = 8'(HOLDOFF - 1);
          state_next = S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        // Last holdoff cycle doubles as IDLE so grants are spaced HOLDOFF+1
        if (cnt_reg == 8'd0) begin
          state_next = S_IDLE;
          grant_ok   = 1'b1;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (grant_ok && found) begin
      state_next      = S_OFFER;
      valid_next      = 1'b1;
      sector_next     = pick;
      last_next       = pick;
      grant_vec[pick] = 1'b1;
    end
  end

  always_comb begin
    pending_next = enable & ((pending_reg & ~grant_vec) | (evt & ~pending_reg));
    lost_add = 0;
    for (int k = 0; k < NSECT; k++) begin
      if (lost_evt[k]) lost_add = lost_add + 1;
    end
    lost_next = (int'(lost_reg) + lost_add > 255) ? 8'd255 : 8'(int'(lost_reg) + lost_add);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      valid_reg   <= 1'b0;
      sector_reg  <= '0;
      last_reg    <= SW'(NSECT - 1);
      cnt_reg     <= 8'd0;
      busy_reg    <= 1'b0;
      lost_reg    <= 8'd0;
      pending_reg <= '0;
      // History reads as "high" so a level held through reset is not an edge
      l2_q_reg    <= '1;
      l2_h_reg    <= '1;
    end else begin
      state_reg   <= state_next;
      valid_reg   <= valid_next;
      sector_reg  <= sector_next;
      last_reg    <= last_next;
      cnt_reg     <= cnt_next;
      busy_reg    <= (state_next != S_IDLE);
      lost_reg    <= lost_next;
      pending_reg <= pending_next;
      l2_q_reg    <= l2;
      l2_h_reg    <= l2_q_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NSECT; gi++) begin : g_sect
      logic [SCALER_W-1:0] live_inc;
      assign live_inc = (evt[gi] && (live_reg[gi] != {SCALER_W{1'b1}}))
                        ? live_reg[gi] + SCALER_W'(1) : live_reg[gi];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          live_reg[gi] <= '0;
          hold_reg[gi] <= '0;
        end else if (scaler_latch) begin
          hold_reg[gi] <= live_inc;
          live_reg[gi] <= '0;
        end else begin
          live_reg[gi] <= live_inc;
        end
      end
    end
  endgenerate

  assign trig_valid  = valid_reg;
  assign trig_sector = sector_reg;
  assign busy        = busy_reg;
  assign lost_cnt    = lost_reg;
  assign scaler_data = hold_reg[scaler_sel];

endmodule

// File: tb/tb_anita4_l2_trigger_scheduler.sv
// Bench for anita4_l2_trigger_scheduler: scenario tasks plus randomized run,
// checked against a timestamp-based behavioural model.
`timescale 1ns/1ps
module tb_anita4_l2_trigger_scheduler;
  localparam int NSECT = 4, HOLDOFF = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] l2 = 4'h0, enable = 4'hF;
  logic trig_ready = 1'b0, scaler_latch = 1'b0;
  logic [1:0] scaler_sel = 2'd0;
  logic trig_valid, busy, trig_valid8, busy8;
  logic [1:0] trig_sector, trig_sector8;
  logic [7:0] lost_cnt, lost_cnt8, scaler_data8;
  logic [15:0] scaler_data;

  anita4_l2_trigger_scheduler #(.NSECT(4), .HOLDOFF(8), .SCALER_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .l2(l2), .enable(enable), .trig_valid(trig_valid),
    .trig_sector(trig_sector), .trig_ready(trig_ready), .busy(busy), .lost_cnt(lost_cnt),
    .scaler_latch(scaler_latch), .scaler_sel(scaler_sel), .scaler_data(scaler_data));
  anita4_l2_trigger_scheduler #(.NSECT(4), .HOLDOFF(8), .SCALER_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .l2(l2), .enable(enable), .trig_valid(trig_valid8),
    .trig_sector(trig_sector8), .trig_ready(trig_ready), .busy(busy8), .lost_cnt(lost_cnt8),
    .scaler_latch(scaler_latch), .scaler_sel(scaler_sel), .scaler_data(scaler_data8));

  always #2 clk = ~clk;

  int checks = 0, errors = 0;

  // Model: offer flag, edge index from which a new grant is allowed, pending set
  int t = 0;
  bit h1 [4], h2 [4], pend [4];
  bit offering;
  int off_sec, last, free_at, lost;
  int live16 [4], held16 [4], live8 [4], held8 [4];

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      h1[i] = 1; h2[i] = 1; pend[i] = 0;
      live16[i] = 0; held16[i] = 0; live8[i] = 0; held8[i] = 0;
    end
    offering = 0; off_sec = 0; last = NSECT - 1; free_at = 0; lost = 0;
  endtask

  task automatic model_edge();
    bit ev [4];
    int g;
    t = t + 1;
    g = -1;
    for (int i = 0; i < 4; i++) ev[i] = h1[i] && !h2[i] && enable[i];
    if (!offering && t >= free_at)
      for (int k = 0; k < NSECT; k++) begin
        int idx;
        idx = (last + 1 + k) % NSECT;
        if (g < 0 && pend[idx] && enable[idx]) g = idx;
      end
    if (offering && trig_ready) begin
      offering = 0; free_at = t + HOLDOFF;
    end else if (g >= 0) begin
      offering = 1; off_sec = g; last = g;
    end
    for (int i = 0; i < 4; i++) begin
      if (ev[i] && pend[i] && lost < 255) lost++;
      pend[i] = enable[i] && ((pend[i] && i != g) || (ev[i] && !pend[i]));
      if (ev[i] && live16[i] < 65535) live16[i]++;
      if (ev[i] && live8[i] < 255) live8[i]++;
      if (scaler_latch) begin
        held16[i] = live16[i]; live16[i] = 0; held8[i] = live8[i]; live8[i] = 0;
      end
      h2[i] = h1[i]; h1[i] = l2[i];
    end
  endtask

  function automatic logic [11:0] exp_vec();
    bit b;
    b = offering || (t < free_at);
    return {offering, 2'(off_sec), b, 8'(lost)};
  endfunction

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_edge();
    @(negedge clk);
  endtask

  task automatic pulse(input int s);
    l2[s] = 1'b1; step();
    l2[s] = 1'b0; step();
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0; l2 = 4'h0; step();
    rst_n = 1'b1; step();
  endtask

  task automatic test_reset();
    model_reset();
    l2 = 4'b0010;
    repeat (3) step();
    checks++;
    if ({trig_valid, trig_sector, busy, lost_cnt, scaler_data} !== 28'h0) begin
      errors++; $display("FAIL reset_state got %h want 0", {trig_valid, trig_sector, busy, lost_cnt, scaler_data});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if ({trig_valid, trig_sector, busy, lost_cnt} !== exp_vec() || trig_valid !== 1'b0) begin
        errors++; $display("FAIL held_l2_release cyc %0d got %h want %h", i, {trig_valid, trig_sector, busy, lost_cnt}, exp_vec());
      end
    end
    l2 = 4'h0; step();
  endtask

  task automatic test_single_hit();
    int first_v = -1, nvalid = 0, nbusy = 0, sec = -1;
    trig_ready = 1'b1;
    l2[2] = 1'b1;
    for (int e = 0; e < 26; e++) begin
      step();
      if (e == 2) l2[2] = 1'b0;
      if (trig_valid) begin nvalid++; if (first_v < 0) begin first_v = e; sec = int'(trig_sector); end end
      if (busy) nbusy++;
      checks++;
      if ({trig_valid, trig_sector, busy, lost_cnt} !== exp_vec()) begin
        errors++; $display("FAIL single_hit_model e %0d got %h want %h", e, {trig_valid, trig_sector, busy, lost_cnt}, exp_vec());
      end
    end
    checks++;
    if (first_v != 2 || nvalid != 1 || sec != 2 || nbusy != 9) begin
      errors++; $display("FAIL single_hit_timing got lat %0d nv %0d sec %0d busy %0d want 2 1 2 9", first_v, nvalid, sec, nbusy);
    end
  endtask

  task automatic test_simultaneous();
    int gs [$], ge [$];
    reset_pulse();
    trig_ready = 1'b1;
    l2 = 4'b1011; step(); l2 = 4'h0;
    for (int e = 1; e < 40; e++) begin
      step();
      if (trig_valid) begin gs.push_back(int'(trig_sector)); ge.push_back(e); end
      checks++;
      if ({trig_valid, trig_sector, busy, lost_cnt} !== exp_vec()) begin
        errors++; $display("FAIL simul_model e %0d got %h want %h", e, {trig_valid, trig_sector, busy, lost_cnt}, exp_vec());
      end
    end
    checks++;
    if (gs.size() != 3 || gs[0] != 0 || gs[1] != 1 || gs[2] != 3 ||
        ge[1] - ge[0] != 9 || ge[2] - ge[1] != 9 || lost_cnt !== 8'd0) begin
      errors++; $display("FAIL simul_order got n %0d lost %0d want sectors 0,1,3 spacing 9 lost 0", gs.size(), lost_cnt);
    end
  endtask

  task automatic test_back_pressure();
    int w = 0;
    trig_ready = 1'b0;
    pulse(1);
    while (!trig_valid && w < 10) begin step(); w++; end
    checks++;
    if (!trig_valid) begin errors++; $display("FAIL bp_offer_timeout got valid 0 want 1"); end
    for (int i = 0; i < 20; i++) begin
      l2[1] = (i == 3 || i == 12);
      step();
      checks++;
      if (trig_valid !== 1'b1 || trig_sector !== 2'd1 || {trig_valid, trig_sector, busy, lost_cnt} !== exp_vec()) begin
        errors++; $display("FAIL bp_stable i %0d got %h want %h", i, {trig_valid, trig_sector, busy, lost_cnt}, exp_vec());
      end
    end
    checks++;
    if (lost_cnt !== 8'd1) begin errors++; $display("FAIL bp_lost got %0d want 1", lost_cnt); end
    trig_ready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step();
      checks++;
      if ({trig_valid, trig_sector, busy, lost_cnt} !== exp_vec()) begin
        errors++; $display("FAIL bp_drain i %0d got %h want %h", i, {trig_valid, trig_sector, busy, lost_cnt}, exp_vec());
      end
    end
  endtask

  task automatic test_masking();
    int w = 0, bad = 0;
    trig_ready = 1'b0;
    pulse(0);
    while (!trig_valid && w < 10) begin step(); w++; end
    pulse(3); step();
    enable = 4'b0111; step();
    trig_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (trig_valid && trig_sector == 2'd3) bad++;
      checks++;
      if ({trig_valid, trig_sector, busy, lost_cnt} !== exp_vec()) begin
        errors++; $display("FAIL mask_model i %0d got %h want %h", i, {trig_valid, trig_sector, busy, lost_cnt}, exp_vec());
      end
    end
    scaler_latch = 1'b1; step(); scaler_latch = 1'b0;
    for (int p = 0; p < 50; p++) begin
      pulse(3);
      if (trig_valid) bad++;
    end
    scaler_latch = 1'b1; step(); scaler_latch = 1'b0;
    scaler_sel = 2'd3; step();
    checks++;
    if (bad != 0 || scaler_data !== 16'd0 || scaler_data !== 16'(held16[3])) begin
      errors++; $display("FAIL mask_result got bad %0d scaler %0d want 0 0", bad, scaler_data);
    end
    enable = 4'hF;
  endtask

  task automatic test_scalers();
    trig_ready = 1'b1;
    scaler_latch = 1'b1; step(); scaler_latch = 1'b0;
    for (int p = 0; p < 300; p++) pulse(0);
    scaler_latch = 1'b1; step(); scaler_latch = 1'b0;
    scaler_sel = 2'd0; step();
    checks++;
    if (scaler_data !== 16'd300 || scaler_data8 !== 8'd255) begin
      errors++; $display("FAIL scaler_300 got %0d/%0d want 300/255", scaler_data, scaler_data8);
    end
    pulse(0);
    scaler_latch = 1'b1; step(); scaler_latch = 1'b0; step();
    checks++;
    if (scaler_data !== 16'd1 || scaler_data8 !== 8'd1) begin
      errors++; $display("FAIL scaler_restart got %0d/%0d want 1/1", scaler_data, scaler_data8);
    end
    for (int p = 0; p < 250; p++) pulse(0);
    checks++;
    if (lost_cnt !== 8'd255 || {trig_valid, trig_sector, busy, lost_cnt} !== exp_vec()) begin
      errors++; $display("FAIL lost_saturate got %0d want 255", lost_cnt);
    end
  endtask

  task automatic test_async_reset();
    int w = 0, fs = -1;
    reset_pulse();
    trig_ready = 1'b0;
    pulse(2);
    pulse(1);
    while (!trig_valid && w < 10) begin step(); w++; end
    #1 rst_n = 1'b0;
    #0.5;
    checks++;
    if ({trig_valid, trig_sector, busy, lost_cnt} !== 12'h0 || scaler_data !== 16'd0) begin
      errors++; $display("FAIL async_reset got %h want 0", {trig_valid, trig_sector, busy, lost_cnt});
    end
    model_reset();
    @(negedge clk);
    step();
    rst_n = 1'b1;
    trig_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({trig_valid, trig_sector, busy, lost_cnt} !== exp_vec() || trig_valid !== 1'b0) begin
        errors++; $display("FAIL post_reset_quiet i %0d got %h want %h", i, {trig_valid, trig_sector, busy, lost_cnt}, exp_vec());
      end
    end
    l2 = 4'b1001; step(); l2 = 4'h0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (trig_valid && fs < 0) fs = int'(trig_sector);
    end
    checks++;
    if (fs != 0) begin errors++; $display("FAIL post_reset_rr got sector %0d want 0", fs); end
  endtask

  task automatic test_random();
    reset_pulse();
    for (int i = 0; i < 3000; i++) begin
      l2 = l2 ^ (4'($urandom) & 4'($urandom));
      enable = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'hF;
      trig_ready = ($urandom_range(0, 3) != 0);
      scaler_latch = ($urandom_range(0, 49) == 0);
      scaler_sel = 2'($urandom);
      rst_n = (i != 1500);
      step();
      checks++;
      if ({trig_valid, trig_sector, busy, lost_cnt} !== exp_vec() ||
          {trig_valid8, trig_sector8, busy8, lost_cnt8} !== exp_vec()) begin
        errors++; $display("FAIL rand_ctrl i %0d got %h/%h want %h", i, {trig_valid, trig_sector, busy, lost_cnt},
                           {trig_valid8, trig_sector8, busy8, lost_cnt8}, exp_vec());
      end
      checks++;
      if (scaler_data !== 16'(held16[scaler_sel]) || scaler_data8 !== 8'(held8[scaler_sel])) begin
        errors++; $display("FAIL rand_scaler i %0d sel %0d got %0d/%0d want %0d/%0d", i, scaler_sel,
                           scaler_data, scaler_data8, held16[scaler_sel], held8[scaler_sel]);
      end
    end
    rst_n = 1'b1; scaler_latch = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_hit();
    test_simultaneous();
    test_back_pressure();
    test_masking();
    test_scalers();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
